// File: rtl/ex_mem_reg.sv
// EX/MEM pipeline register: 2-entry skid FIFO between EX and MEM,
// also holds the committed architectural flags.
module ex_mem_reg #(
  parameter int LENGTH = 32,
  parameter int RD_W   = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [LENGTH-1:0] in_result,
  input  logic [3:0]        in_flags,
  input  logic [RD_W-1:0]   in_rd,
  input  logic              in_wr_en,
  input  logic              in_set_flags,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [LENGTH-1:0] out_result,
  output logic [3:0]        out_flags,
  output logic [RD_W-1:0]   out_rd,
  output logic              out_wr_en,
  output logic [3:0]        status_flags
);

  typedef struct packed {
    logic [LENGTH-1:0] result;
    logic [3:0]        flags;
    logic [RD_W-1:0]   rd;
    logic              wr_en;
    logic              set_flags;
  } ex_mem_t;

  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] ONE   = 2'd1;
  localparam logic [1:0] FULL  = 2'd2;

  logic [1:0] state_q, state_nx;
  ex_mem_t    head_q, head_nx;
  ex_mem_t    skid_q, skid_nx;
  ex_mem_t    in_ent;
  logic [3:0] stat_q, stat_nx;
  logic       accept, commit;

  assign in_ready  = (state_q == EMPTY) || (state_q == ONE);
  assign out_valid = (state_q == ONE) || (state_q == FULL);
  assign accept    = in_valid & in_ready;
  assign commit    = out_valid & out_ready;

  always_comb begin
    in_ent.result    = in_result;
    in_ent.flags     = in_flags;
    in_ent.rd        = in_rd;
    in_ent.wr_en     = in_wr_en;
    in_ent.set_flags = in_set_flags;
  end

  always_comb begin
    state_nx = state_q;
    head_nx  = head_q;
    skid_nx  = skid_q;
    if (flush) begin
      state_nx = EMPTY;
    end else begin
      unique case (1'b1)
        state_q == EMPTY: begin
          if (accept) begin
            head_nx  = in_ent;
            state_nx = ONE;
          end
        end
        state_q == ONE: begin
          if (accept && commit) begin
            head_nx = in_ent;
          end else if (accept) begin
            skid_nx  = in_ent;
            state_nx = FULL;
          end else if (commit) begin
            state_nx = EMPTY;
          end
        end
        state_q == FULL: begin
          // in_ready is low here, so only the skid promotion can happen
          if (commit) begin
            head_nx  = skid_q;
            state_nx = ONE;
          end
        end
        default: state_nx = EMPTY;
      endcase
    end
  end

  // a committing head still updates the flags when flush coincides
  always_comb begin
    stat_nx = stat_q;
    if (commit && head_q.set_flags) begin
      stat_nx = head_q.flags;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      head_q  <= '0;
      skid_q  <= '0;
      stat_q  <= 4'b0000;
    end else begin
      state_q <= state_nx;
      head_q  <= head_nx;
      skid_q  <= skid_nx;
      stat_q  <= stat_nx;
    end
  end

  assign out_result   = out_valid ? head_q.result : '0;
  assign out_flags    = out_valid ? head_q.flags  : 4'b0000;
  assign out_rd       = out_valid ? head_q.rd     : '0;
  assign out_wr_en    = out_valid & head_q.wr_en;
  assign status_flags = stat_q;

endmodule

// File: tb/tb_ex_mem_reg.sv
// Bench for ex_mem_reg: queue-based reference FIFO with a
// decoupled monitor, directed scenarios then random traffic.
module tb_ex_mem_reg;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_result = '0;
  logic [3:0]  in_flags = '0;
  logic [4:0]  in_rd = '0;
  logic        in_wr_en = 1'b0;
  logic        in_set_flags = 1'b0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_result;
  logic [3:0]  out_flags;
  logic [4:0]  out_rd;
  logic        out_wr_en;
  logic [3:0]  status_flags;

  typedef struct {
    logic [31:0] r;
    logic [3:0]  f;
    logic [4:0]  d;
    logic        we;
    logic        sf;
  } ent_t;

  ent_t       exp_q[$];
  logic [3:0] exp_flags = 4'b0000;
  int         checks = 0;
  int         errors = 0;

  ex_mem_reg #(.LENGTH(32), .RD_W(5)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_result(in_result), .in_flags(in_flags),
    .in_rd(in_rd), .in_wr_en(in_wr_en),
    .in_set_flags(in_set_flags), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_flags(out_flags),
    .out_rd(out_rd), .out_wr_en(out_wr_en),
    .status_flags(status_flags)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, req,
               $time);
    end
  endtask

  // monitor: samples on the falling edge, before the commit edge
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      exp_flags = 4'b0000;
    end else begin
      chk("status_flags", {28'd0, status_flags}, {28'd0, exp_flags});
      if (!out_valid) begin
        chk("idle_wr_en", {31'd0, out_wr_en}, 32'd0);
        chk("idle_result", out_result, 32'd0);
      end else if (exp_q.size() == 0) begin
        chk("unexpected_out", {31'd0, out_valid}, 32'd0);
      end else begin
        chk("out_result", out_result, exp_q[0].r);
        chk("out_flags", {28'd0, out_flags}, {28'd0, exp_q[0].f});
        chk("out_rd", {27'd0, out_rd}, {27'd0, exp_q[0].d});
        chk("out_wr_en", {31'd0, out_wr_en}, {31'd0, exp_q[0].we});
        if (out_ready) begin
          if (exp_q[0].sf) exp_flags = exp_q[0].f;
          void'(exp_q.pop_front());
        end
      end
      if (flush) exp_q.delete();
    end
  end

  // one cycle of stimulus; entries the model accepts join the scoreboard
  task automatic step(input logic iv, input logic [31:0] r,
                      input logic [3:0] f, input logic [4:0] d,
                      input logic we, input logic sf,
                      input logic ordy, input logic fl,
                      input logic rs);
    ent_t e;
    @(posedge clk);
    #1;
    chk("in_ready", {31'd0, in_ready}, {31'd0, exp_q.size() < 2});
    chk("out_valid", {31'd0, out_valid}, {31'd0, exp_q.size() > 0});
    in_valid     = iv;
    in_result    = r;
    in_flags     = f;
    in_rd        = d;
    in_wr_en     = we;
    in_set_flags = sf;
    out_ready    = ordy;
    flush        = fl;
    rst          = rs;
    if (iv && !fl && !rs && exp_q.size() < 2) begin
      e.r  = r;
      e.f  = f;
      e.d  = d;
      e.we = we;
      e.sf = sf;
      exp_q.push_back(e);
    end
  endtask

  task automatic idle(input logic ordy);
    step(1'b0, 32'd0, 4'd0, 5'd0, 1'b0, 1'b0, ordy, 1'b0, 1'b0);
  endtask

  task automatic put(input logic [31:0] r, input logic [3:0] f,
                     input logic sf, input logic ordy);
    step(1'b1, r, f, r[4:0], r[0], sf, ordy, 1'b0, 1'b0);
  endtask

  initial begin
    step(1'b0, 32'd0, 4'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(1'b0);

    // single result, 1-cycle latency, flags 0000 committed
    put(32'h5, 4'b0000, 1'b1, 1'b1);
    idle(1'b1);
    chk("lat_out_valid", {31'd0, out_valid}, 32'd1);
    chk("lat_out_result", out_result, 32'h5);
    idle(1'b1);
    chk("lat_status", {28'd0, status_flags}, 32'd0);

    // A, B, C back to back with MEM stalled; C is refused
    put(32'hA, 4'b0010, 1'b0, 1'b0);
    put(32'hB, 4'b0001, 1'b0, 1'b0);
    put(32'hC, 4'b0011, 1'b0, 1'b0);
    idle(1'b1);
    idle(1'b1);
    idle(1'b1);

    // streaming in ONE: accept and commit every cycle
    put(32'h100, 4'b1000, 1'b1, 1'b0);
    for (int i = 1; i <= 4; i++) put(32'h100 + i, 4'(i), 1'b1, 1'b1);
    idle(1'b1);
    idle(1'b1);

    // flush while FULL with a new offer
    put(32'h200, 4'b0000, 1'b0, 1'b0);
    put(32'h201, 4'b0000, 1'b0, 1'b0);
    step(1'b1, 32'h202, 4'd0, 5'd2, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(1'b1);
    chk("flush_empty", {31'd0, out_valid}, 32'd0);
    idle(1'b1);

    // flags sticky across a set_flags=0 commit
    put(32'h300, 4'b1001, 1'b1, 1'b1);
    put(32'h301, 4'b0100, 1'b0, 1'b1);
    idle(1'b1);
    idle(1'b1);
    chk("sticky_flags", {28'd0, status_flags}, 32'h9);

    // reset while FULL and MEM ready
    put(32'h400, 4'b0110, 1'b1, 1'b0);
    put(32'h401, 4'b0111, 1'b1, 1'b0);
    step(1'b0, 32'd0, 4'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    idle(1'b1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_status", {28'd0, status_flags}, 32'd0);

    for (int i = 0; i < 800; i++) begin
      step($urandom_range(0, 3) != 0, $urandom, 4'($urandom),
           5'($urandom), 1'($urandom), 1'($urandom),
           $urandom_range(0, 2) != 0, $urandom_range(0, 24) == 0,
           $urandom_range(0, 99) == 0);
    end
    idle(1'b1);
    idle(1'b1);
    idle(1'b1);
    @(posedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks,
             errors);
    $finish;
  end

endmodule
